// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: byte handshake in, framed serial out on tx.
// Also sequences an external registered parity generator.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] par_data,
    output logic       par_load,
    output logic       par_signal,
    input  logic       par_in,
    output logic       tx,
    output logic       busy
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic ODD = (PARITY_ODD != 0);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, CALC, START, DATA, PARITY, STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;
    logic             par_r;
    logic             bit_end;

    assign bit_end = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            par_r      <= 1'b0;
            par_data   <= '0;
            par_load   <= 1'b0;
            par_signal <= 1'b0;
            tx         <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shift    <= tx_data;
                        par_data <= tx_data;
                        par_load <= 1'b1;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    par_load   <= 1'b0;
                    par_signal <= 1'b1;
                    state      <= CALC;
                end
                CALC: begin
                    par_signal <= 1'b0;
                    tx         <= 1'b0;
                    cnt        <= '0;
                    state      <= START;
                end
                START: begin
                    // generator output settles one cycle after CALC
                    if (cnt == '0)
                        par_r <= par_in ^ ODD;
                    if (bit_end) begin
                        cnt   <= '0;
                        idx   <= '0;
                        tx    <= shift[0];
                        state <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        shift <= {1'b0, shift[7:1]};
                        idx   <= idx + 1'b1;
                        if (idx == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                tx    <= par_r;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            tx <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    // idx wrapped to 0 after the last data bit; reuse it
                    if (bit_end) begin
                        cnt <= '0;
                        if (idx == LAST_STOP) begin
                            idx      <= '0;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: vector table plus scoreboard of expected frames.
// Three instances: defaults, odd parity, and a short no-parity 2-stop config.
module tb_uart_tx_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] tx_data, tx_data2;
    logic       tx_valid, tx_valid2;
    logic       rdy0, rdy1, rdy2, ld0, ld1, ld2, sg0, sg1, sg2;
    logic       tx0, tx1, tx2, bsy0, bsy1, bsy2, pin0, pin1, pin2;
    logic [7:0] pd0, pd1, pd2, st0, st1, st2;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int hs_q[$];

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       pbit;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [7:0] data;
        logic       p_even;
        logic       p_odd;
    } vec_t;
    vec_t vec[6];

    uart_tx_ctrl u_def (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy0), .par_data(pd0), .par_load(ld0),
        .par_signal(sg0), .par_in(pin0), .tx(tx0), .busy(bsy0)
    );
    uart_tx_ctrl #(.PARITY_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy1), .par_data(pd1), .par_load(ld1),
        .par_signal(sg1), .par_in(pin1), .tx(tx1), .busy(bsy1)
    );
    uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(2)) u_cfg (
        .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(rdy2), .par_data(pd2), .par_load(ld2),
        .par_signal(sg2), .par_in(pin2), .tx(tx2), .busy(bsy2)
    );

    // registered parity generator models
    always_ff @(posedge clk or posedge rst)
        if (rst) begin st0 <= '0; pin0 <= 1'b0; end
        else begin
            if (ld0) st0 <= pd0;
            if (sg0) pin0 <= ^st0;
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin st1 <= '0; pin1 <= 1'b0; end
        else begin
            if (ld1) st1 <= pd1;
            if (sg1) pin1 <= ^st1;
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin st2 <= '0; pin2 <= 1'b0; end
        else begin
            if (ld2) st2 <= pd2;
            if (sg2) pin2 <= ^st2;
        end

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk)
        if (!rst && tx_valid && rdy0) hs_q.push_back(cyc);

    function automatic logic g_tx(int s);
        case (s) 0: return tx0; 1: return tx1; default: return tx2; endcase
    endfunction
    function automatic logic g_rdy(int s);
        case (s) 0: return rdy0; 1: return rdy1; default: return rdy2; endcase
    endfunction
    function automatic logic g_bsy(int s);
        case (s) 0: return bsy0; 1: return bsy1; default: return bsy2; endcase
    endfunction
    function automatic logic g_ld(int s);
        case (s) 0: return ld0; 1: return ld1; default: return ld2; endcase
    endfunction
    function automatic logic g_sg(int s);
        case (s) 0: return sg0; 1: return sg1; default: return sg2; endcase
    endfunction
    function automatic logic [7:0] g_pd(int s);
        case (s) 0: return pd0; 1: return pd1; default: return pd2; endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            chk("load_signal_excl", g_ld(s) & g_sg(s), 0);
            chk("ready_vs_busy", g_rdy(s), !g_bsy(s));
        end
    end

    task automatic push_exp(input int s, input logic [7:0] d,
                            input logic p);
        exp_t t;
        t.sel = s; t.data = d; t.pbit = p;
        sbq.push_back(t);
    endtask

    function automatic logic exp_bit(exp_t e, int b, int pe);
        if (b == 0) return 1'b0;
        if (b <= 8) return e.data[b-1];
        if (b == 9 && pe != 0) return e.pbit;
        return 1'b1;
    endfunction

    // returns at the negedge of the LOAD cycle
    task automatic do_hs(input int s, input logic [7:0] d,
                         input logic hold);
        int w = 0;
        if (s == 2) begin tx_data2 = d; tx_valid2 = 1'b1; end
        else begin tx_data = d; tx_valid = 1'b1; end
        while (!g_rdy(s) && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("hs_ready", g_rdy(s), 1);
        @(negedge clk);
        if (!hold) begin
            if (s == 2) tx_valid2 = 1'b0;
            else tx_valid = 1'b0;
        end
    endtask

    task automatic chk_frame(input int n, input int cpb, input int pe,
                             input int sb);
        exp_t e[2];
        logic bad[2];
        logic act[2];
        int nb = 1 + 8 + pe + sb;
        for (int i = 0; i < n; i++) begin
            if (sbq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL scoreboard: got empty queue expected entry");
                return;
            end
            e[i] = sbq.pop_front();
        end
        for (int i = 0; i < n; i++) begin
            chk("par_load_k1", g_ld(e[i].sel), 1);
            chk("par_signal_k1", g_sg(e[i].sel), 0);
            chk("par_data", g_pd(e[i].sel), e[i].data);
        end
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            chk("par_load_k2", g_ld(e[i].sel), 0);
            chk("par_signal_k2", g_sg(e[i].sel), 1);
        end
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 2; i++) begin bad[i] = 0; act[i] = 0; end
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                for (int i = 0; i < n; i++) begin
                    if (g_tx(e[i].sel) !== exp_bit(e[i], b, pe) ||
                        g_rdy(e[i].sel) !== 1'b0) begin
                        bad[i] = 1;
                        act[i] = g_tx(e[i].sel);
                    end
                end
            end
            for (int i = 0; i < n; i++) begin
                n_chk++;
                if (bad[i]) begin
                    n_fail++;
                    $display("FAIL frame_bit inst%0d byte %02h slot %0d: tx=%0b ready=%0b expected tx=%0b ready=0",
                             e[i].sel, e[i].data, b, act[i],
                             g_rdy(e[i].sel), exp_bit(e[i], b, pe));
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < n; i++)
            chk("ready_after_frame", g_rdy(e[i].sel), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{8'hA5, 1'b0, 1'b1};
        vec[1] = '{8'h07, 1'b1, 1'b0};
        vec[2] = '{8'h00, 1'b0, 1'b1};
        vec[3] = '{8'hFF, 1'b0, 1'b1};
        vec[4] = '{8'h80, 1'b1, 1'b0};
        vec[5] = '{8'h3C, 1'b0, 1'b1};

        rst = 1'b1;
        tx_valid = 1'b1; tx_data = 8'hA5;
        tx_valid2 = 1'b1; tx_data2 = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                chk("rst_tx", g_tx(s), 1);
                chk("rst_ready", g_rdy(s), 1);
                chk("rst_busy", g_bsy(s), 0);
                chk("rst_load", g_ld(s), 0);
                chk("rst_signal", g_sg(s), 0);
                chk("rst_par_data", g_pd(s), 0);
            end
        end
        rst = 1'b0;
        tx_valid2 = 1'b0;

        for (int i = 0; i < 6; i++) begin
            push_exp(0, vec[i].data, vec[i].p_even);
            push_exp(1, vec[i].data, vec[i].p_odd);
            do_hs(0, vec[i].data, 1'b0);
            chk_frame(2, 16, 1, 1);
        end

        hs_q.delete();
        push_exp(0, 8'h55, 1'b0);
        push_exp(1, 8'h55, 1'b1);
        do_hs(0, 8'h55, 1'b1);
        tx_data = 8'h80;
        chk_frame(2, 16, 1, 1);
        push_exp(0, 8'h80, 1'b1);
        push_exp(1, 8'h80, 1'b0);
        @(negedge clk);
        tx_data = 8'h3C;
        tx_valid = 1'b0;
        chk_frame(2, 16, 1, 1);
        chk("hs_count", hs_q.size(), 2);
        if (hs_q.size() == 2)
            chk("hs_spacing", hs_q[1] - hs_q[0], 179);

        push_exp(2, 8'hFF, 1'b0);
        do_hs(2, 8'hFF, 1'b0);
        chk_frame(1, 4, 0, 2);

        do_hs(0, 8'h10, 1'b0);
        repeat (1 + 16 + 20) @(negedge clk);
        chk("mid_data_tx", tx0, 0);
        chk("mid_data_busy", bsy0, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_tx", tx0, 1);
        chk("async_rst_ready", rdy0, 1);
        chk("async_rst_busy", bsy0, 0);
        chk("async_rst_par_data", pd0, 0);
        chk("async_rst_tx_odd", tx1, 1);
        @(negedge clk);
        rst = 1'b0;

        push_exp(0, 8'hA5, 1'b0);
        push_exp(1, 8'hA5, 1'b1);
        do_hs(0, 8'hA5, 1'b0);
        chk_frame(2, 16, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
